// File: rtl/latch_event_monitor_if.sv
// Event stream interface for latch_event_monitor.
// The monitor (master) presents the show-ahead head of its event FIFO.
// The consumer (slave) pops that head by asserting evt_ready while evt_valid is high.
interface latch_event_monitor_if #(
  parameter int CNT_W = 8
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [1:0]       evt_kind;
  logic [CNT_W-1:0] evt_data;

  modport master (output evt_valid, output evt_kind, output evt_data, input evt_ready);
  modport slave  (input evt_valid, input evt_kind, input evt_data, output evt_ready);
endinterface

// File: rtl/latch_event_monitor.sv
// latch_event_monitor: observer on the en/d/q pins of a d_latch instance.
// It samples the pins every clock and timestamps each enable edge with the
// length of the phase that just ended. Events are queued in a small
// valid/ready FIFO.
// Define LATCH_MON_CHECK_EN to compile in the transparency/hold checker.
// That build adds ERR events and the saturating err_count. Without the macro,
// err_count is tied to 0 and only RISE/FALL events are produced.
module latch_event_monitor #(
  parameter int CNT_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  d_i,
  input  logic                  q_i,
  latch_event_monitor_if.master evt,
  output logic [7:0]            err_count,
  output logic                  overflow
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DUR_MAX = '1;

  typedef enum logic [1:0] {
    KIND_RISE = 2'd0,
    KIND_FALL = 2'd1,
    KIND_ERR  = 2'd2
  } evt_kind_e;

  typedef struct packed {
    evt_kind_e        kind;
    logic [CNT_W-1:0] data;
  } evt_t;

  logic             s_valid;
  logic             s_en;
  logic             s_en_prev;
  logic             prime;
  logic [CNT_W-1:0] dur;

  logic             active;
  logic             rise;
  logic             fall;
  logic             edge_hit;
  logic             viol;
  logic [CNT_W-1:0] err_data;
  logic             push;
  logic             pop;
  logic             full;
  logic             accept;
  evt_t             push_evt;

  evt_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Sample stage: register the enable and remember the previous sample; the
  // first sample after reset only primes s_en_prev.
  always_ff @(posedge clk) begin
    // NOTE: state is assigned with <= so every register sees pre-edge values.
    if (rst) begin
      s_valid   <= 1'b0;
      s_en      <= 1'b0;
      s_en_prev <= 1'b0;
      prime     <= 1'b1;
    end else begin
      s_valid <= 1'b1;
      s_en    <= en_i;
      if (s_valid) begin
        s_en_prev <= s_en;
        prime     <= 1'b0;
      end
    end
  end

  assign active   = s_valid && !prime;
  assign rise     = active &&  s_en && !s_en_prev;
  assign fall     = active && !s_en &&  s_en_prev;
  assign edge_hit = rise || fall;

  // Phase-length counter: restarts at 1 on prime or an edge and saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      dur <= '0;
    end else if (s_valid) begin
      if (prime || edge_hit) begin
        dur <= CNT_W'(1);
      end else if (dur != DUR_MAX) begin
        dur <= dur + CNT_W'(1);
      end
    end
  end

`ifdef LATCH_MON_CHECK_EN
  logic       s_d;
  logic       s_q;
  logic       s_dref;
  logic       settle;
  logic [7:0] err_q;

  // Checker state: the expected q follows d while transparent and freezes when
  // closed. The slot right after an edge or prime is left to settle.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_d    <= 1'b0;
      s_q    <= 1'b0;
      s_dref <= 1'b0;
      settle <= 1'b0;
      err_q  <= 8'd0;
    end else begin
      s_d <= d_i;
      s_q <= q_i;
      if (s_valid) begin
        settle <= prime || edge_hit;
        if (s_en) begin
          s_dref <= s_d;
        end
      end
      if (viol && err_q != 8'hFF) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  assign viol      = active && !settle && (s_q != s_dref);
  assign err_count = err_q;

  // ERR payload: observed q and reference value in the two low bits.
  always_comb begin
    err_data      = '0;
    err_data[1:0] = {s_q, s_dref};
  end
`else
  logic unused_pins;
  assign unused_pins = ^{d_i, q_i};
  assign viol        = 1'b0;
  assign err_count   = 8'd0;
  assign err_data    = '0;
`endif

  // One push per cycle: an edge always wins over a coincident violation.
  always_comb begin
    // NOTE: defaults first so no path leaves push_evt unassigned (no latch).
    push_evt.kind = KIND_RISE;
    push_evt.data = dur;
    if (edge_hit) begin
      push_evt.kind = rise ? KIND_RISE : KIND_FALL;
    end else if (viol) begin
      push_evt.kind = KIND_ERR;
      push_evt.data = err_data;
    end
  end

  assign push   = edge_hit || viol;
  assign pop    = evt.evt_valid && evt.evt_ready;
  assign full   = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign accept = push && (!full || pop);

  // Event FIFO: a pop frees a slot in the same cycle, and a push on full
  // without a pop is dropped and flagged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      // NOTE: the few entries are reset because the head drives the outputs,
      // which must read 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_evt;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign evt.evt_valid = (count != '0);
  assign evt.evt_kind  = mem[rd_ptr].kind;
  assign evt.evt_data  = mem[rd_ptr].data;

endmodule
